i2s_frame_sequencer: RTL and testbench
======================================

Name: i2s_frame_sequencer

Overview:
- Master-mode I2S frame controller between the Tx/Rx FIFOs and the serial pins.
- Generates sck/ws from pclk and sequences FIFO pops/pushes per channel slot.
- Serializes Tx words MSB-first and deserializes Rx words, using the word_len/mono/clk_div control fields from the register block.
- Reports underrun/overrun pulses for the flag register.

Parameters:
- DATA_W, 32, FIFO word width and fixed channel slot length in sck cycles.
- DIV_W, 8, width of clk_div.

Ports:
- pclk  in  1  system clock
- preset  in  1  async active-low reset
- enable  in  1  run request from control register
- clk_div  in  DIV_W  sck half-period minus one, in pclk cycles
- word_len  in  2  00=16, 01=24, 10=32, 11=32 valid bits per slot
- mono  in  1  1 = single word per frame, duplicated on right channel
- tx_empty  in  1  Tx FIFO empty
- tx_data  in  DATA_W  Tx FIFO head word (first-word-fall-through)
- tx_ren  out  1  Tx FIFO pop, 1-pclk pulse
- rx_full  in  1  Rx FIFO full
- rx_data  out  DATA_W  assembled Rx word
- rx_wen  out  1  Rx FIFO push, 1-pclk pulse
- sck  out  1  serial clock
- ws  out  1  word select (0=left, 1=right)
- sd_tx  out  1  serial data out
- sd_rx  in  1  serial data in
- busy  out  1  high when not IDLE
- tx_underrun  out  1  1-pclk pulse
- rx_overrun  out  1  1-pclk pulse

Behaviour:
- Clock and reset: clock pclk; reset preset, asynchronous, active-low. On reset, all outputs are 0, state is IDLE, and counters and shift registers are 0.
- Divider:
  - div_cnt counts 0..clk_div, then wraps and toggles sck. sck half-period is clk_div+1 pclk cycles; clk_div=0 gives sck = pclk/2.
  - "fall" and "rise" are the single pclk cycles in which sck toggles 1->0 and 0->1.
  - clk_div, word_len and mono are latched at frame start (IDLE->LEFT). Changes take effect at the next frame start.
- Bit counter: bit_cnt 0..DATA_W-1 per slot, incremented on fall, wraps to 0.
- States: IDLE, LEFT, RIGHT, DRAIN.
  - IDLE: sck=0, ws=0, sd_tx=0, divider held. If enable=1, go to LEFT: ws=0, load the left shift register, and the divider starts the next cycle.
  - LEFT -> RIGHT on the fall where bit_cnt wraps. ws<=1 and the shift register is reloaded.
  - RIGHT -> LEFT on the wrap fall if enable=1, else -> DRAIN. ws<=0.
  - DRAIN: runs exactly one more sck period so the final Rx bit is captured, then goes to IDLE. sck ends low.
- Load (each slot start):
  - If !tx_empty, the shift register gets tx_data and tx_ren pulses in that same cycle.
  - Else the shift register gets 0 and tx_underrun pulses.
  - With mono=1, the RIGHT load reuses the left word with no pop and no underrun.
- Tx timing (I2S one-bit delay): sd_tx changes on fall. The first valid bit (bit DATA_W-1) is driven on the fall after the ws toggle. Bits beyond word_len in a slot are driven as 0.
- Rx timing:
  - sd_rx is sampled on rise. Valid bits are the first word_len rising edges after the one-bit delay.
  - The word is MSB-aligned in rx_data; unused LSBs are 0.
  - On the fall following the last valid sample: if !rx_full, rx_wen pulses with rx_data stable; else rx_overrun pulses and the word is dropped.
  - With mono=1, the right-channel Rx word is discarded silently.
- Simultaneous pop/push in one cycle is allowed.
- enable deassertion mid-frame always completes the current stereo frame (left+right) before IDLE. There are no partial frames.
- Reset mid-frame aborts immediately to the reset values.

Optional Feature:
- I2S_LOOPBACK_EN defined: the internal Rx sampler takes sd_tx instead of sd_rx. This gives an internal loopback for self-test, and the sd_rx port is ignored.
- Undefined: sd_rx is used and there is no loopback logic.

Test Plan:
- Reset with preset=0 mid-frame -> sck=ws=sd_tx=tx_ren=rx_wen=busy=0 immediately. Stays IDLE with enable=0.
- clk_div=1, word_len=00, mono=0, Tx FIFO holds 0xA5A50000, 0x5A5A0000, enable=1 for one frame:
  - sck period = 4 pclk.
  - ws toggles every 32 sck.
  - sd_tx shows 1010... MSB one sck after each ws edge, then 16 zeros.
  - Two tx_ren pulses.
- Tx FIFO empty at RIGHT load -> one tx_underrun pulse. Right slot serializes all zeros, with no tx_ren.
- I2S_LOOPBACK_EN, word_len=10, tx words 0x12345678 / 0x9ABCDEF0 -> rx_wen pulses twice with rx_data equal to the same words, in order.
- rx_full=1 during the left push -> rx_overrun pulses and no rx_wen. The right push succeeds after rx_full drops.
- Deassert enable during LEFT -> the frame completes through RIGHT and DRAIN, then busy=0 and sck=0. Exactly 2 pops total.

Source files
------------

// File: rtl/i2s_frame_sequencer_if.sv
// i2s_frame_sequencer_if: Tx/Rx FIFO handshake between the I2S sequencer (master) and the FIFOs (slave).
interface i2s_frame_sequencer_if #(parameter int DATA_W = 32);
  logic tx_empty;
  logic [DATA_W-1:0] tx_data;
  logic tx_ren;
  logic rx_full;
  logic [DATA_W-1:0] rx_data;
  logic rx_wen;
  modport master(input tx_empty, tx_data, rx_full, output tx_ren, rx_data, rx_wen);
  modport slave(output tx_empty, tx_data, rx_full, input tx_ren, rx_data, rx_wen);
endinterface

// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer: master-mode I2S frame controller (sck/ws generation, Tx serialize, Rx deserialize).
// Define I2S_LOOPBACK_EN to feed sd_tx into the Rx sampler instead of sd_rx.
module i2s_frame_sequencer #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [1:0]       word_len,
  input  logic             mono,
  i2s_frame_sequencer_if.master fifo,
  output logic             sck,
  output logic             ws,
  output logic             sd_tx,
  input  logic             sd_rx,
  output logic             busy,
  output logic             tx_underrun,
  output logic             rx_overrun
);
  localparam int BW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, DRAIN} state_t;
  state_t state, state_nx;
  logic [DIV_W-1:0] div_cnt, div_l;
  logic [1:0] wl_l;
  logic mono_l;
  logic [BW-1:0] bit_cnt, rx_pos;
  logic [BW:0] wl_bits;
  logic [DATA_W-1:0] tx_sh, rx_sh, left_word, load_word;
  logic rx_pend, rx_right;
  logic start, tick, fall, rise, wrap, load, load_left, pop, push, keep, sd_in;
`ifdef I2S_LOOPBACK_EN
  assign sd_in = sd_tx;
`else
  assign sd_in = sd_rx;
`endif
  assign start = enable && preset;
  assign tick = state != IDLE && div_cnt == div_l;
  assign fall = tick && sck;
  assign rise = tick && !sck;
  assign wrap = fall && bit_cnt == BW'(DATA_W - 1);
  assign wl_bits = wl_l == 2'b00 ? (BW+1)'(16) : wl_l == 2'b01 ? (BW+1)'(24) : (BW+1)'(DATA_W);
  // Rx lags Tx by one bit: the sample on a rise belongs to the bit driven on the previous fall
  assign rx_pos = bit_cnt - 1'b1;
  always_ff @(posedge pclk or negedge preset)
    if (!preset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    load = 1'b0;
    load_left = 1'b0;
    case (state)
      IDLE: begin
        state_nx = start ? LEFT : IDLE;
        load = start;
        load_left = start;
      end
      LEFT: begin
        state_nx = wrap ? RIGHT : LEFT;
        load = wrap;
      end
      RIGHT: begin
        state_nx = wrap ? (enable ? LEFT : DRAIN) : RIGHT;
        load = wrap && enable;
        load_left = wrap && enable;
      end
      default: state_nx = fall ? IDLE : DRAIN;
    endcase
    pop = load && (load_left || !mono_l);
    fifo.tx_ren = pop && !fifo.tx_empty;
    tx_underrun = pop && fifo.tx_empty;
    load_word = !pop ? left_word : fifo.tx_empty ? '0 : fifo.tx_data;
    push = fall && rx_pend && bit_cnt == wl_bits[BW-1:0];
    keep = !(mono_l && rx_right);
    fifo.rx_wen = push && keep && !fifo.rx_full;
    rx_overrun = push && keep && fifo.rx_full;
    fifo.rx_data = rx_sh << ((BW+1)'(DATA_W) - wl_bits);
    busy = state != IDLE;
  end
  always_ff @(posedge pclk or negedge preset)
    if (!preset) begin
      div_cnt <= '0;
      div_l <= '0;
      wl_l <= '0;
      mono_l <= 1'b0;
      sck <= 1'b0;
      ws <= 1'b0;
      sd_tx <= 1'b0;
      bit_cnt <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      left_word <= '0;
      rx_pend <= 1'b0;
      rx_right <= 1'b0;
    end else begin
      if (state == IDLE) begin
        div_cnt <= '0;
        sck <= 1'b0;
        ws <= 1'b0;
        sd_tx <= 1'b0;
        bit_cnt <= '0;
        if (start) begin
          div_l <= clk_div;
          wl_l <= word_len;
          mono_l <= mono;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        sck <= sck ^ tick;
      end
      if (fall) begin
        bit_cnt <= bit_cnt + 1'b1;
        sd_tx <= state != DRAIN && tx_sh[DATA_W-1] && ({1'b0, bit_cnt} < wl_bits);
        tx_sh <= tx_sh << 1;
      end
      if (wrap) ws <= state == LEFT;
      if (load) tx_sh <= load_word;
      if (load_left) left_word <= load_word;
      if (rise && rx_pos == '0) begin
        rx_sh <= DATA_W'(sd_in);
        rx_pend <= 1'b1;
        rx_right <= state == RIGHT;
      end else if (rise && {1'b0, rx_pos} < wl_bits) rx_sh <= {rx_sh[DATA_W-2:0], sd_in};
      if (push) rx_pend <= 1'b0;
    end
endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// tb_i2s_frame_sequencer: table-driven frame vectors plus hand-written reset sequences.
module tb_i2s_frame_sequencer;
  localparam int DATA_W = 32;
  logic pclk = 1'b0, preset = 1'b0, enable = 1'b0, mono = 1'b0;
  logic [7:0] clk_div = '0;
  logic [1:0] word_len = '0;
  logic sck, ws, sd_tx, sd_rx, busy, tx_underrun, rx_overrun;
  i2s_frame_sequencer_if #(.DATA_W(DATA_W)) fifo();
  i2s_frame_sequencer #(.DATA_W(DATA_W), .DIV_W(8)) dut (
    .pclk(pclk), .preset(preset), .enable(enable), .clk_div(clk_div), .word_len(word_len),
    .mono(mono), .fifo(fifo), .sck(sck), .ws(ws), .sd_tx(sd_tx), .sd_rx(sd_rx), .busy(busy),
    .tx_underrun(tx_underrun), .rx_overrun(rx_overrun)
  );
  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] div;
    logic [1:0] wl;
    logic mono, src, full;
    int nf, nw, pops, unders, wens, ovrs;
    logic [3:0][31:0] w, s, rx;
  } vec_t;
  vec_t tv[10];

  int n_cmp = 0, n_bad = 0;
  logic [3:0][31:0] tx_mem = '0, cur_s = '0, got;
  int wr_cnt = 0, rd_ptr, cur_wl = 16;
  logic full_mode = 1'b0, full_drop, src_one = 1'b0;
  assign fifo.tx_empty = rd_ptr >= wr_cnt;
  assign fifo.tx_data = fifo.tx_empty ? 32'h0 : tx_mem[rd_ptr[1:0]];
  assign fifo.rx_full = full_mode && !full_drop;
  assign sd_rx = src_one ? 1'b1 : sd_tx;

  always @(posedge pclk or negedge preset)
    if (!preset) begin
      rd_ptr <= 0;
      full_drop <= 1'b0;
    end else begin
      if (fifo.tx_ren) rd_ptr <= rd_ptr + 1;
      if (rx_overrun) full_drop <= 1'b1;
    end

  int cyc = 0, n_pop, n_und, n_wen, n_ovr, n_rise, n_err, bad_r, t1, t2, k;
  logic sck_q;
  logic [31:0] wd;
  logic eb;
  // Independent I2S model: rise r carries bit (r-1)%32 of slot (r-1)/32; ws is high for rises 32..63 of each frame
  always @(negedge pclk) begin
    cyc++;
    if (!preset) begin
      n_pop = 0; n_und = 0; n_wen = 0; n_ovr = 0; n_rise = 0; n_err = 0;
      bad_r = -1; t1 = 0; t2 = 0; got = '0; sck_q = 1'b0;
    end else begin
      n_pop += int'(fifo.tx_ren);
      n_und += int'(tx_underrun);
      n_ovr += int'(rx_overrun);
      if (fifo.rx_wen) begin
        if (n_wen < 4) got[n_wen[1:0]] = fifo.rx_data;
        n_wen++;
      end
      if (sck && !sck_q) begin
        if (n_rise == 1) t1 = cyc;
        if (n_rise == 2) t2 = cyc;
        if (n_rise >= 1) begin
          k = (n_rise - 1) % 32;
          wd = cur_s[((n_rise - 1) / 32) % 4];
          eb = (k < cur_wl) ? wd[31-k] : 1'b0;
          if (sd_tx !== eb || ws !== (((n_rise / 32) % 2) == 1)) begin
            n_err++;
            if (bad_r < 0) bad_r = n_rise;
          end
        end
        n_rise++;
      end
      sck_q = sck;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] div, input logic [1:0] wl, input logic mo, sr, fu,
                              input int nf, nw, pops, unders, wens, ovrs,
                              input logic [3:0][31:0] w, s, rx);
    vec_t v;
    v.div = div; v.wl = wl; v.mono = mo; v.src = sr; v.full = fu;
    v.nf = nf; v.nw = nw; v.pops = pops; v.unders = unders; v.wens = wens; v.ovrs = ovrs;
    v.w = w; v.s = s; v.rx = rx;
    return v;
  endfunction

  task automatic run(input int i);
    vec_t v;
    int t;
    v = tv[i];
    preset = 1'b0; enable = 1'b0;
    clk_div = v.div; word_len = v.wl; mono = v.mono; src_one = v.src; full_mode = v.full;
    tx_mem = v.w; wr_cnt = v.nw; cur_s = v.s;
    cur_wl = v.wl == 2'b00 ? 16 : v.wl == 2'b01 ? 24 : 32;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b1; enable = 1'b1;
    @(posedge pclk);
    #1 clk_div = ~v.div; word_len = ~v.wl; mono = ~v.mono;
    if (v.nf == 1) enable = 1'b0;
    else begin
      t = 0;
      while (n_rise < 70 && t < 2000) begin @(negedge pclk); t++; end
      enable = 1'b0;
    end
    t = 0;
    while (busy && t < 3000) begin @(negedge pclk); t++; end
    chk($sformatf("v%0d frame done", i), {31'b0, busy}, 32'd0);
    repeat (2) @(negedge pclk);
    chk($sformatf("v%0d tx_ren count", i), n_pop, v.pops);
    chk($sformatf("v%0d underrun count", i), n_und, v.unders);
    chk($sformatf("v%0d rx_wen count", i), n_wen, v.wens);
    chk($sformatf("v%0d overrun count", i), n_ovr, v.ovrs);
    chk($sformatf("v%0d sd_tx/ws errors (first bad rise %0d)", i, bad_r), n_err, 0);
    chk($sformatf("v%0d sck period", i), t2 - t1, 2 * (int'(v.div) + 1));
    chk($sformatf("v%0d sck/ws idle", i), {30'b0, sck, ws}, 32'd0);
    for (int j = 0; j < v.wens && j < 4; j++) chk($sformatf("v%0d rx word %0d", i, j), got[j], v.rx[j]);
  endtask

  initial begin
    preset = 1'b0; enable = 1'b1; wr_cnt = 1; tx_mem[0] = 32'hFFFF_FFFF;
    #12;
    chk("reset outputs", {24'b0, sck, ws, sd_tx, fifo.tx_ren, fifo.rx_wen, busy, tx_underrun, rx_overrun}, 32'd0);
    chk("reset rx_data", fifo.rx_data, 32'd0);
    @(posedge pclk); #1 preset = 1'b1;
    repeat (40) @(negedge pclk);
    chk("busy mid frame", {31'b0, busy}, 32'd1);
    @(posedge pclk); #1 preset = 1'b0;
    #1 chk("async reset mid frame", {26'b0, sck, ws, sd_tx, fifo.tx_ren, fifo.rx_wen, busy}, 32'd0);
    enable = 1'b0;
    @(posedge pclk); #1 preset = 1'b1;
    repeat (20) @(negedge pclk);
    chk("idle after reset busy/sck", {30'b0, busy, sck}, 32'd0);
    chk("idle after reset pops", n_pop, 0);

    tv[0] = mk(8'd1, 2'b00, 0, 0, 0, 1, 2, 2, 0, 2, 0,
               {32'h0, 32'h0, 32'h5A5A0000, 32'hA5A50000}, {32'h0, 32'h0, 32'h5A5A0000, 32'hA5A50000},
               {32'h0, 32'h0, 32'h5A5A0000, 32'hA5A50000});
    tv[1] = mk(8'd0, 2'b10, 0, 0, 0, 1, 2, 2, 0, 2, 0,
               {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678}, {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678},
               {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678});
    tv[2] = mk(8'd2, 2'b01, 0, 0, 0, 1, 2, 2, 0, 2, 0,
               {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678}, {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678},
               {32'h0, 32'h0, 32'h9ABCDE00, 32'h12345600});
    tv[3] = mk(8'd0, 2'b00, 0, 0, 0, 1, 1, 1, 1, 2, 0,
               {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
               {32'h0, 32'h0, 32'h0, 32'hDEAD0000});
    tv[4] = mk(8'd0, 2'b10, 0, 0, 1, 1, 2, 2, 0, 1, 1,
               {32'h0, 32'h0, 32'h22222222, 32'h11111111}, {32'h0, 32'h0, 32'h22222222, 32'h11111111},
               {32'h0, 32'h0, 32'h0, 32'h22222222});
    tv[5] = mk(8'd1, 2'b10, 1, 0, 0, 1, 2, 1, 0, 1, 0,
               {32'h0, 32'h0, 32'h0BADBEEF, 32'hCAFEF00D}, {32'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D},
               {32'h0, 32'h0, 32'h0, 32'hCAFEF00D});
    tv[6] = mk(8'd0, 2'b00, 0, 1, 0, 1, 0, 0, 2, 2, 0,
               {32'h0, 32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0, 32'h0},
               {32'h0, 32'h0, 32'hFFFF0000, 32'hFFFF0000});
    tv[7] = mk(8'd3, 2'b11, 0, 0, 0, 1, 2, 2, 0, 2, 0,
               {32'h0, 32'h0, 32'h7FFFFFFE, 32'h80000001}, {32'h0, 32'h0, 32'h7FFFFFFE, 32'h80000001},
               {32'h0, 32'h0, 32'h7FFFFFFE, 32'h80000001});
    tv[8] = mk(8'd0, 2'b10, 0, 0, 0, 2, 4, 4, 0, 4, 0,
               {32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567},
               {32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567},
               {32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567});
    tv[9] = mk(8'd0, 2'b00, 1, 0, 0, 1, 0, 0, 1, 1, 0,
               {32'h0, 32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0, 32'h0});
    for (int i = 0; i < 10; i++) run(i);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
